// File: rtl/psram_sched_if.sv
// Requester-side bus of psram_sched: per-requester request slices plus shared completion/read data.
interface psram_sched_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    valid;
    logic [NUM_REQ-1:0]    rdwr;
    logic [NUM_REQ*32-1:0] addr;
    logic [NUM_REQ*64-1:0] wr_data;
    logic [NUM_REQ*8-1:0]  wr_mask;
    logic [NUM_REQ-1:0]    done;
    logic [63:0]           rd_data;

    modport master (
        output valid, rdwr, addr, wr_data, wr_mask,
        input  done, rd_data
    );

    modport slave (
        input  valid, rdwr, addr, wr_data, wr_mask,
        output done, rd_data
    );
endinterface

// File: rtl/psram_sched.sv
// Front-end for psram_core: runs PSRAM power-up/config sequence, then round-robin
// arbitrates requesters onto the single core transfer port, one transaction at a time.
module psram_sched #(
    parameter int unsigned NUM_REQ   = 2,
    parameter logic [15:0] PU_CYCLES = 16'd1500
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [7:0]   mr0_i,
    input  logic [7:0]   mr4_i,
    output logic         init_done_o,
    psram_sched_if.slave req,
    output logic         core_xfer_valid_o,
    output logic         core_xfer_rdwr_o,
    input  logic         core_xfer_ready_i,
    output logic [31:0]  core_bus_addr_o,
    output logic [63:0]  core_bus_wr_data_o,
    output logic [7:0]   core_bus_wr_mask_o,
    input  logic [63:0]  core_bus_rd_data_i,
    output logic         core_cfg_cflg_o,
    output logic [7:0]   core_cfg_ccmd_o,
    output logic [31:0]  core_cfg_addr_o,
    output logic [7:0]   core_cfg_data_o
);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {PWUP, ARB, ISSUE, BUSY, DONE} state_e;

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [1:0]     step_q, step_d;
    logic           init_done_q, init_done_d;
    logic [IW-1:0]  last_q, last_d;
    logic           valid_q, valid_d;
    logic           rdwr_q, rdwr_d;
    logic [31:0]    addr_q, addr_d;
    logic [63:0]    wdata_q, wdata_d;
    logic [7:0]     mask_q, mask_d;
    logic           cflg_q, cflg_d;
    logic [7:0]     ccmd_q, ccmd_d;
    logic [31:0]    caddr_q, caddr_d;
    logic [7:0]     cdata_q, cdata_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [63:0]    rd_data_q, rd_data_d;

    logic           any_valid;
    logic [IW-1:0]  gnt_idx;
    int unsigned    cand;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        any_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!any_valid && req.valid[IW'(cand)]) begin
                any_valid = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= PWUP;
            cnt_q       <= PU_CYCLES - 16'd1;
            step_q      <= '0;
            init_done_q <= 1'b0;
            last_q      <= '0;
            valid_q     <= 1'b0;
            rdwr_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            cflg_q      <= 1'b0;
            ccmd_q      <= '0;
            caddr_q     <= '0;
            cdata_q     <= '0;
            done_q      <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            init_done_q <= init_done_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            rdwr_q      <= rdwr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            cflg_q      <= cflg_d;
            ccmd_q      <= ccmd_d;
            caddr_q     <= caddr_d;
            cdata_q     <= cdata_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PWUP:    if (cnt_q == '0) state_d = ARB;
            ARB:     if (!init_done_q || any_valid) state_d = ISSUE;
            ISSUE:   if (!core_xfer_ready_i) state_d = BUSY;
            BUSY:    if (core_xfer_ready_i) state_d = DONE;
            DONE:    state_d = ARB;
            default: state_d = PWUP;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        step_d      = step_q;
        init_done_d = init_done_q;
        last_d      = last_q;
        valid_d     = 1'b0;
        rdwr_d      = rdwr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        cflg_d      = cflg_q;
        ccmd_d      = ccmd_q;
        caddr_d     = caddr_q;
        cdata_d     = cdata_q;
        done_d      = '0;
        rd_data_d   = rd_data_q;
        case (state_q)
            PWUP: if (cnt_q != '0) cnt_d = cnt_q - 16'd1;
            ARB: begin
                if (!init_done_q) begin
                    valid_d = 1'b1;
                    cflg_d  = 1'b1;
                    rdwr_d  = 1'b0;
                    case (step_q)
                        2'd0:    begin ccmd_d = 8'hFF; caddr_d = 32'h0; cdata_d = 8'h00;  end
                        2'd1:    begin ccmd_d = 8'hC0; caddr_d = 32'h0; cdata_d = mr0_i;  end
                        default: begin ccmd_d = 8'hC0; caddr_d = 32'h4; cdata_d = mr4_i;  end
                    endcase
                end else if (any_valid) begin
                    valid_d = 1'b1;
                    cflg_d  = 1'b0;
                    last_d  = gnt_idx;
                    rdwr_d  = req.rdwr[gnt_idx];
                    addr_d  = req.addr[gnt_idx*32 +: 32];
                    wdata_d = req.wr_data[gnt_idx*64 +: 64];
                    mask_d  = req.wr_mask[gnt_idx*8 +: 8];
                end
            end
            ISSUE: valid_d = core_xfer_ready_i;
            // Completion is registered on the BUSY->DONE edge so it is visible during DONE.
            BUSY: begin
                if (core_xfer_ready_i && !cflg_q) begin
                    done_d[last_q] = 1'b1;
                    if (rdwr_q) rd_data_d = core_bus_rd_data_i;
                end
            end
            DONE: begin
                if (cflg_q) begin
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd2) init_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Masking with ready removes valid in the very cycle the core reports busy.
    assign core_xfer_valid_o  = valid_q & core_xfer_ready_i;
    assign core_xfer_rdwr_o   = rdwr_q;
    assign core_bus_addr_o    = addr_q;
    assign core_bus_wr_data_o = wdata_q;
    assign core_bus_wr_mask_o = mask_q;
    assign core_cfg_cflg_o    = cflg_q;
    assign core_cfg_ccmd_o    = ccmd_q;
    assign core_cfg_addr_o    = caddr_q;
    assign core_cfg_data_o    = cdata_q;
    assign init_done_o        = init_done_q;
    assign req.done           = done_q;
    assign req.rd_data        = rd_data_q;
endmodule

// File: tb/tb_psram_sched.sv
// Self-checking bench for psram_sched with a behavioural psram_core stand-in and a
// round-robin grant-order model.
module tb_psram_sched;
    localparam int unsigned NR = 2;
    localparam logic [15:0] PU = 16'd8;

    typedef struct { logic rdwr; logic [31:0] addr; logic [63:0] wdata; logic [7:0] mask; } xfer_t;
    typedef struct { logic cflg; logic [7:0] ccmd; logic [31:0] caddr; logic [7:0] cdata;
                     logic rdwr; logic [31:0] addr; logic [63:0] wdata; logic [7:0] mask;
                     logic [63:0] rd; } launch_t;
    typedef struct { logic [NR-1:0] done; logic [63:0] rd; } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] mr0 = 8'h00, mr4 = 8'h00;
    logic init_done, core_valid, core_rdwr, core_ready, core_cflg;
    logic [31:0] core_addr, cfg_addr;
    logic [63:0] core_wdata, core_rd_data;
    logic [7:0] core_mask, ccmd, cdata;

    psram_sched_if #(.NUM_REQ(NR)) rif ();

    psram_sched #(.NUM_REQ(NR), .PU_CYCLES(PU)) dut (
        .clk_i(clk), .rst_i(rst), .mr0_i(mr0), .mr4_i(mr4), .init_done_o(init_done),
        .req(rif),
        .core_xfer_valid_o(core_valid), .core_xfer_rdwr_o(core_rdwr),
        .core_xfer_ready_i(core_ready),
        .core_bus_addr_o(core_addr), .core_bus_wr_data_o(core_wdata),
        .core_bus_wr_mask_o(core_mask), .core_bus_rd_data_i(core_rd_data),
        .core_cfg_cflg_o(core_cflg), .core_cfg_ccmd_o(ccmd),
        .core_cfg_addr_o(cfg_addr), .core_cfg_data_o(cdata)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    xfer_t   pend[NR][$];
    xfer_t   expx[NR][$];
    launch_t launch_q[$];
    done_t   done_q[$];
    int      exp_grant[$];
    int      model_last = 0;

    // Core stand-in: launches after a random trigger delay, then holds ready low.
    logic        cm_busy = 1'b0;
    int          cm_cnt = 0, cm_trig = 0;
    logic [63:0] cm_next_rd = 64'h0F1E2D3C4B5A6978;
    int          lo_min = 3, lo_max = 20;
    logic        rd_force_en = 1'b0;
    logic [63:0] rd_force = '0;
    int          stab_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            core_ready <= 1'b1;
            cm_busy    <= 1'b0;
            cm_trig    <= 0;
        end else if (!cm_busy) begin
            if (core_valid) begin
                if (cm_trig == 0) begin
                    launch_q.push_back('{core_cflg, ccmd, cfg_addr, cdata, core_rdwr, core_addr,
                                         core_wdata, core_mask, rd_force_en ? rd_force : cm_next_rd});
                    core_rd_data <= rd_force_en ? rd_force : cm_next_rd;
                    cm_next_rd   <= {$urandom, $urandom};
                    core_ready   <= 1'b0;
                    cm_busy      <= 1'b1;
                    cm_cnt       <= int'($urandom_range(lo_max, lo_min));
                    cm_trig      <= int'($urandom_range(3, 0));
                end else begin
                    cm_trig <= cm_trig - 1;
                end
            end
        end else begin
            if (launch_q.size() > 0) begin
                if (core_cflg !== launch_q[$].cflg || ccmd !== launch_q[$].ccmd ||
                    cfg_addr !== launch_q[$].caddr || cdata !== launch_q[$].cdata ||
                    core_rdwr !== launch_q[$].rdwr || core_addr !== launch_q[$].addr ||
                    core_wdata !== launch_q[$].wdata || core_mask !== launch_q[$].mask)
                    stab_err <= stab_err + 1;
            end
            if (cm_cnt == 0) begin
                core_ready <= 1'b1;
                cm_busy    <= 1'b0;
            end else begin
                cm_cnt <= cm_cnt - 1;
            end
        end
    end

    int cyc = 0, first_valid_cyc = -1, viol = 0;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            first_valid_cyc <= -1;
        end else begin
            if (core_valid && first_valid_cyc < 0) first_valid_cyc <= cyc;
            if (core_valid && !core_ready) viol <= viol + 1;
            if (rif.done != '0) done_q.push_back('{rif.done, rif.rd_data});
        end
    end

    task automatic drive_step();
        for (int k = 0; k < NR; k++) begin
            if (rif.done[k] && pend[k].size() > 0) void'(pend[k].pop_front());
            if (pend[k].size() > 0) begin
                rif.valid[k]             = 1'b1;
                rif.rdwr[k]              = pend[k][0].rdwr;
                rif.addr[k*32 +: 32]     = pend[k][0].addr;
                rif.wr_data[k*64 +: 64]  = pend[k][0].wdata;
                rif.wr_mask[k*8 +: 8]    = pend[k][0].mask;
            end else begin
                rif.valid[k] = 1'b0;
            end
        end
    endtask

    task automatic run(input int target, input int budget, output bit ok);
        int c = 0;
        while (done_q.size() < target && c < budget) begin
            @(negedge clk);
            drive_step();
            c++;
        end
        ok = (done_q.size() >= target);
        repeat (8) begin
            @(negedge clk);
            drive_step();
        end
    endtask

    task automatic wait_init(input int budget, output bit ok);
        int c = 0;
        while (!init_done && c < budget) begin
            @(negedge clk);
            drive_step();
            c++;
        end
        ok = init_done;
    endtask

    task automatic load(input int k, input logic rdwr, input logic [31:0] addr);
        xfer_t x;
        x.rdwr  = rdwr;
        x.addr  = addr;
        x.wdata = {$urandom, $urandom};
        x.mask  = 8'($urandom);
        pend[k].push_back(x);
        expx[k].push_back(x);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Reference arbitration: next grant is the first requester with work after the last one.
    function automatic void predict(input int n[NR]);
        int rem[NR];
        int total = 0;
        rem = n;
        for (int k = 0; k < NR; k++) total += rem[k];
        while (total > 0) begin
            bit found = 1'b0;
            for (int i = 1; i <= NR; i++) begin
                int c = (model_last + i) % NR;
                if (!found && rem[c] > 0) begin
                    found = 1'b1;
                    rem[c]--;
                    total--;
                    exp_grant.push_back(c);
                    model_last = c;
                end
            end
        end
    endfunction

    task automatic test_reset();
        rif.valid = '0; rif.rdwr = '0; rif.addr = '0; rif.wr_data = '0; rif.wr_mask = '0;
        mr0 = 8'($urandom);
        mr4 = 8'($urandom);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (init_done !== 1'b0 || core_valid !== 1'b0 || core_cflg !== 1'b0 || core_rdwr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got done=%b valid=%b cflg=%b rdwr=%b required all 0",
                     init_done, core_valid, core_cflg, core_rdwr);
        end
        checks++;
        if ({core_addr, core_wdata, core_mask} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h mask=%h required 0", core_addr, core_wdata, core_mask);
        end
        checks++;
        if ({ccmd, cfg_addr, cdata} !== '0) begin
            errors++;
            $display("FAIL reset_cfg: got ccmd=%h addr=%h data=%h required 0", ccmd, cfg_addr, cdata);
        end
        checks++;
        if (rif.done !== '0 || rif.rd_data !== '0) begin
            errors++;
            $display("FAIL reset_req: got done=%b rd=%h required 0", rif.done, rif.rd_data);
        end
        model_last = 0;
        rst = 1'b0;
    endtask

    task automatic test_init_sequence();
        logic [7:0]  eccmd[3];
        logic [31:0] ecaddr[3];
        logic [7:0]  ecdata[3];
        int bl = launch_q.size();
        bit ok;
        eccmd  = '{8'hFF, 8'hC0, 8'hC0};
        ecaddr = '{32'h0, 32'h0, 32'h4};
        ecdata = '{8'h00, mr0, mr4};
        wait_init(1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL init_timeout: init_done=%b required 1", init_done);
        end
        checks++;
        if (first_valid_cyc != int'(PU) + 1) begin
            errors++;
            $display("FAIL first_valid_cycle: got %0d required %0d", first_valid_cyc, int'(PU) + 1);
        end
        checks++;
        if (launch_q.size() != bl + 3) begin
            errors++;
            $display("FAIL init_count: got %0d required 3", launch_q.size() - bl);
        end else begin
            for (int i = 0; i < 3; i++) begin
                launch_t L = launch_q[bl + i];
                checks++;
                if (L.cflg !== 1'b1 || L.rdwr !== 1'b0 || L.ccmd !== eccmd[i] ||
                    L.caddr !== ecaddr[i] || L.cdata !== ecdata[i]) begin
                    errors++;
                    $display("FAIL init_cmd%0d: got cflg=%b rdwr=%b ccmd=%h addr=%h data=%h required 1 0 %h %h %h",
                             i, L.cflg, L.rdwr, L.ccmd, L.caddr, L.cdata, eccmd[i], ecaddr[i], ecdata[i]);
                end
            end
        end
    endtask

    task automatic test_single_read();
        int bl = launch_q.size();
        int bd = done_q.size();
        bit ok;
        rd_force_en = 1'b1;
        rd_force    = 64'hDEADBEEF_01234567;
        load(0, 1'b1, 32'h100);
        void'(expx[0].pop_front());
        run(bd + 1, 500, ok);
        rd_force_en = 1'b0;
        model_last  = 0;
        checks++;
        if (!ok || done_q.size() != bd + 1 || launch_q.size() != bl + 1) begin
            errors++;
            $display("FAIL read_count: got dones=%0d launches=%0d required 1 1",
                     done_q.size() - bd, launch_q.size() - bl);
        end else begin
            checks++;
            if (done_q[bd].done !== 2'b01 || done_q[bd].rd !== 64'hDEADBEEF_01234567) begin
                errors++;
                $display("FAIL read_done: got done=%b rd=%h required 01 deadbeef01234567",
                         done_q[bd].done, done_q[bd].rd);
            end
            checks++;
            if (launch_q[bl].cflg !== 1'b0 || launch_q[bl].rdwr !== 1'b1 || launch_q[bl].addr !== 32'h100) begin
                errors++;
                $display("FAIL read_core: got cflg=%b rdwr=%b addr=%h required 0 1 00000100",
                         launch_q[bl].cflg, launch_q[bl].rdwr, launch_q[bl].addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bl = launch_q.size();
        int bd = done_q.size();
        int v0 = viol, s0 = stab_err;
        bit ok;
        lo_min = 3;
        lo_max = 6;
        for (int i = 0; i < 4; i++) begin
            load(0, 1'($urandom), $urandom);
            load(1, 1'($urandom), $urandom);
        end
        run(bd + 8, 2000, ok);
        checks++;
        if (!ok || done_q.size() != bd + 8 || launch_q.size() != bl + 8) begin
            errors++;
            $display("FAIL b2b_count: got dones=%0d launches=%0d required 8 8",
                     done_q.size() - bd, launch_q.size() - bl);
        end else begin
            for (int i = 0; i < 8; i++) begin
                int k = (i % 2 == 0) ? 1 : 0;
                xfer_t x = expx[k].pop_front();
                launch_t L = launch_q[bl + i];
                logic [NR-1:0] eb = '0;
                eb[k] = 1'b1;
                checks++;
                if (L.cflg !== 1'b0 || L.rdwr !== x.rdwr || L.addr !== x.addr ||
                    L.wdata !== x.wdata || L.mask !== x.mask) begin
                    errors++;
                    $display("FAIL b2b_grant%0d: got addr=%h rdwr=%b required req%0d addr=%h rdwr=%b",
                             i, L.addr, L.rdwr, k, x.addr, x.rdwr);
                end
                checks++;
                if (done_q[bd + i].done !== eb || (x.rdwr && done_q[bd + i].rd !== L.rd)) begin
                    errors++;
                    $display("FAIL b2b_done%0d: got done=%b rd=%h required %b rd=%h",
                             i, done_q[bd + i].done, done_q[bd + i].rd, eb, L.rd);
                end
            end
        end
        model_last = 0;
        checks++;
        if (viol != v0 || stab_err != s0) begin
            errors++;
            $display("FAIL b2b_protocol: got valid_while_busy=%0d unstable=%0d required 0 0",
                     viol - v0, stab_err - s0);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n[NR];
            int total = 0;
            int bl = launch_q.size();
            int bd = done_q.size();
            int v0 = viol, s0 = stab_err;
            bit ok;
            lo_min = 0;
            lo_max = int'($urandom_range(20, 2));
            for (int k = 0; k < NR; k++) begin
                n[k] = int'($urandom_range(3, 0));
                total += n[k];
            end
            if (total == 0) begin
                n[r % NR] = 1;
                total = 1;
            end
            for (int k = 0; k < NR; k++)
                for (int j = 0; j < n[k]; j++) load(k, 1'($urandom), $urandom);
            predict(n);
            run(bd + total, 3000, ok);
            checks++;
            if (!ok || done_q.size() != bd + total || launch_q.size() != bl + total) begin
                errors++;
                $display("FAIL rand%0d_count: got dones=%0d launches=%0d required %0d",
                         r, done_q.size() - bd, launch_q.size() - bl, total);
                exp_grant.delete();
                for (int k = 0; k < NR; k++) expx[k].delete();
            end else begin
                for (int i = 0; i < total; i++) begin
                    int k = exp_grant.pop_front();
                    xfer_t x = expx[k].pop_front();
                    launch_t L = launch_q[bl + i];
                    logic [NR-1:0] eb = '0;
                    eb[k] = 1'b1;
                    checks++;
                    if (L.cflg !== 1'b0 || L.rdwr !== x.rdwr || L.addr !== x.addr ||
                        L.wdata !== x.wdata || L.mask !== x.mask || done_q[bd + i].done !== eb ||
                        (x.rdwr && done_q[bd + i].rd !== L.rd)) begin
                        errors++;
                        $display("FAIL rand%0d_xfer%0d: got addr=%h done=%b rd=%h required req%0d addr=%h done=%b rd=%h",
                                 r, i, L.addr, done_q[bd + i].done, done_q[bd + i].rd, k, x.addr, eb, L.rd);
                    end
                end
            end
            checks++;
            if (viol != v0 || stab_err != s0) begin
                errors++;
                $display("FAIL rand%0d_protocol: got valid_while_busy=%0d unstable=%0d required 0 0",
                         r, viol - v0, stab_err - s0);
            end
        end
    endtask

    task automatic test_pwup_request();
        int bl, bd;
        bit ok;
        xfer_t x;
        apply_reset(2);
        model_last = 0;
        bl = launch_q.size();
        bd = done_q.size();
        repeat (2) @(posedge clk);
        #1;
        load(1, 1'b0, 32'h0000_2468);
        x = expx[1].pop_front();
        run(bd + 1, 1500, ok);
        model_last = 1;
        checks++;
        if (!ok || launch_q.size() != bl + 4 || done_q.size() != bd + 1) begin
            errors++;
            $display("FAIL pwup_count: got launches=%0d dones=%0d required 4 1",
                     launch_q.size() - bl, done_q.size() - bd);
        end else begin
            checks++;
            if (launch_q[bl].cflg !== 1'b1 || launch_q[bl + 1].cflg !== 1'b1 || launch_q[bl + 2].cflg !== 1'b1) begin
                errors++;
                $display("FAIL pwup_order: got cflg=%b%b%b required 111",
                         launch_q[bl].cflg, launch_q[bl + 1].cflg, launch_q[bl + 2].cflg);
            end
            checks++;
            if (launch_q[bl + 3].cflg !== 1'b0 || launch_q[bl + 3].addr !== x.addr ||
                launch_q[bl + 3].wdata !== x.wdata || done_q[bd].done !== 2'b10) begin
                errors++;
                $display("FAIL pwup_xfer: got cflg=%b addr=%h done=%b required 0 %h 10",
                         launch_q[bl + 3].cflg, launch_q[bl + 3].addr, done_q[bd].done, x.addr);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int bl = launch_q.size();
        int bd, c = 0;
        bit ok;
        lo_min = 20;
        lo_max = 20;
        load(0, 1'b1, 32'h0000_0ABC);
        while (launch_q.size() == bl && c < 200) begin
            @(negedge clk);
            drive_step();
            c++;
        end
        repeat (3) begin
            @(negedge clk);
            drive_step();
        end
        checks++;
        if (core_ready !== 1'b0 || launch_q.size() != bl + 1) begin
            errors++;
            $display("FAIL midbusy_setup: got ready=%b launches=%0d required 0 1", core_ready, launch_q.size() - bl);
        end
        bd = done_q.size();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (core_valid !== 1'b0 || core_cflg !== 1'b0 || init_done !== 1'b0 || rif.done !== '0) begin
            errors++;
            $display("FAIL midbusy_reset: got valid=%b cflg=%b init_done=%b done=%b required 0 0 0 0",
                     core_valid, core_cflg, init_done, rif.done);
        end
        for (int k = 0; k < NR; k++) begin
            pend[k].delete();
            expx[k].delete();
        end
        rif.valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_last = 0;
        lo_min = 3;
        lo_max = 20;
        bl = launch_q.size();
        wait_init(1000, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || launch_q.size() != bl + 3 || first_valid_cyc != int'(PU) + 1) begin
            errors++;
            $display("FAIL midbusy_reinit: got init_done=%b cfg_cmds=%0d first_valid=%0d required 1 3 %0d",
                     init_done, launch_q.size() - bl, first_valid_cyc, int'(PU) + 1);
        end else begin
            checks++;
            if (launch_q[bl].ccmd !== 8'hFF || launch_q[bl + 1].cdata !== mr0 || launch_q[bl + 2].cdata !== mr4) begin
                errors++;
                $display("FAIL midbusy_cmds: got %h/%h/%h required ff/%h/%h",
                         launch_q[bl].ccmd, launch_q[bl + 1].cdata, launch_q[bl + 2].cdata, mr0, mr4);
            end
        end
        checks++;
        if (done_q.size() != bd) begin
            errors++;
            $display("FAIL midbusy_nodone: got %0d done pulses required 0", done_q.size() - bd);
        end
    endtask

    initial begin
        test_reset();
        test_init_sequence();
        test_single_read();
        test_back_to_back();
        test_random();
        test_pwup_request();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/psram_sched.md
# psram_sched

Transfer scheduler placed in front of `psram_core`. After reset it runs the PSRAM power-up sequence (wait, global reset, two mode-register writes) through the core's config-command path. It then round-robin arbitrates `NUM_REQ` bus requesters onto the core's single transfer port. For the whole core transaction it holds every core input stable and returns read data with a one-cycle done pulse.

## Interface
- `NUM_REQ`, 2: number of requesters (2..4).
- `PU_CYCLES`, 16'd1500: power-up wait in `clk_i` cycles before the first command (≥1).
- `clk_i` in 1: system clock, same clock as `psram_core`.
- `rst_i` in 1: reset, synchronous and active-high.
- `mr0_i`, `mr4_i` in 8 each: values written to PSRAM MR0 and MR4 during init.
- `init_done_o` out 1: high once init completes; reset 0.
- `req_valid_i` in NUM_REQ: request; held until its `req_done_o`.
- `req_rdwr_i` in NUM_REQ: 1 = read, 0 = write.
- `req_addr_i` in NUM_REQ*32: address, slice k.
- `req_wr_data_i` in NUM_REQ*64: write data, slice k.
- `req_wr_mask_i` in NUM_REQ*8: write mask, slice k.
- `req_done_o` out NUM_REQ: one-cycle completion pulse; reset 0.
- `req_rd_data_o` out 64: read data, valid with any `req_done_o`; reset 0.
- `core_xfer_valid_o`, `core_xfer_rdwr_o` out 1 each: to core `xfer_valid_i` / `xfer_rdwr_i`; reset 0.
- `core_xfer_ready_i` in 1: core `xfer_ready_o` (core FSM idle).
- `core_bus_addr_o` 32, `core_bus_wr_data_o` 64, `core_bus_wr_mask_o` 8 out: bus fields; reset 0.
- `core_bus_rd_data_i` in 64: core read data.
- `core_cfg_cflg_o` out 1: config-command flag; reset 0.
- `core_cfg_ccmd_o` 8, `core_cfg_addr_o` 32, `core_cfg_data_o` 8 out: config command, address and data; reset 0.

## Operation
- FSM states: PWUP, ARB, ISSUE, BUSY, DONE. Reset enters PWUP with counter = `PU_CYCLES`-1 and init step = 0.
- PWUP: decrement the counter. At 0, go to ARB.
- ARB while `init_done_o`=0: load a config command from the init step, then go to ISSUE. Every config command sets `core_cfg_cflg_o`=1 and `core_xfer_rdwr_o`=0.
  - Step 0: ccmd 0xFF, addr 0, data 0 (global reset).
  - Step 1: ccmd 0xC0, addr 0x0, data `mr0_i`.
  - Step 2: ccmd 0xC0, addr 0x4, data `mr4_i`.
- ARB while `init_done_o`=1: grant the first requester k with `req_valid_i[k]` set, searching from `last`+1 and wrapping. Latch addr/data/mask/rdwr slice k into the core output registers, set `core_cfg_cflg_o`=0, set `last`=k, go to ISSUE. If no request is valid, stay in ARB.
- ISSUE: `core_xfer_valid_o`=1 until the first cycle `core_xfer_ready_i`=0 is seen. In that cycle drop valid and go to BUSY.
- BUSY: valid=0; all other core outputs held unchanged. When `core_xfer_ready_i`=1, go to DONE.
- DONE (one cycle):
  - Requester transfer: pulse `req_done_o[k]`. On a read, register `core_bus_rd_data_i` into `req_rd_data_o`.
  - Init command: increment the step. After step 2, set `init_done_o`=1 (stays 1 until reset).
  - Then return to ARB.
- Requests arriving during init are held pending; no grant is made until `init_done_o`=1.
- Only one transaction is outstanding at a time; a new grant happens only from ARB.
- Arbitration sees only `req_valid_i`. A requester that drops valid before grant is simply skipped. Dropping valid after grant is illegal and is ignored; the transfer completes.
- Reset at any time, including mid-BUSY: all outputs reach reset values on the next edge, and init is re-run. The integration resets `psram_core` on the same reset.

## Timing
- `core_xfer_valid_o` goes high the cycle after the ARB decision.
- The core samples valid only on its divided-clock trigger. ISSUE length therefore varies, from 1 up to 32 cycles at DIV32. No timeout.
- Core fields are stable from the ARB→ISSUE edge until the DONE→ARB edge. Valid is never high while in BUSY, so the core cannot re-launch.
- `req_done_o` and `req_rd_data_o` are registered, one cycle after `core_xfer_ready_i` rises.
- ARB-to-ARB minimum cost is 4 cycles plus core duration.
- Back-to-back grants are possible; the next grant's ARB cycle immediately follows DONE.
- `init_done_o` rises in the DONE cycle of step 2, visible on the next edge.

## Test plan
- PU_CYCLES=8, core model with ready low for 20 cycles per transfer:
  - No valid before cycle 8.
  - Three config transactions with (cflg,ccmd,addr,data) = (1,FF,0,0), (1,C0,0,mr0_i), (1,C0,4,mr4_i).
  - Then `init_done_o`=1.
- Read from req0 at addr 0x100, core rd data 0xDEADBEEF_01234567 → `req_done_o`=01 for one cycle, `req_rd_data_o` = that value, core rdwr=1, cflg=0.
- req0 and req1 held valid continuously → grants alternate 1,0,1,0 (`last` resets to 0), each with its own addr/data on the core port.
- Requests raised at cycle 2 (during PWUP) → no core activity until init completes; the request is then served first.
- `rst_i` asserted mid-BUSY → next edge: valid=0, cflg=0, `init_done_o`=0, no done pulse; the PWUP/init sequence repeats.
- Core ready low held 3 cycles after valid → valid drops the same cycle ready falls and is never re-asserted before DONE.
